spl_split: RTL and testbench

SPL_SPLIT -- requirements
Module: spl

---
 rtl/spl_split.sv | 86 ++++++++
 tb/tb_spl_split.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/spl_split.sv
// Two-way packet splitter: in_data[ROUTE_BIT] steers each packet into one of two
// independent single-entry output registers, each with its own valid/ready handshake.
module spl_split #(
   parameter int WIDTH     = 11,
   parameter int ROUTE_BIT = 10
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out1_valid,
   input  logic             out1_ready,
   output logic [WIDTH-1:0] out1_data,
   output logic             out2_valid,
   input  logic             out2_ready,
   output logic [WIDTH-1:0] out2_data
);

   logic             out1_valid_r;
   logic [WIDTH-1:0] out1_data_r;
   logic             out2_valid_r;
   logic [WIDTH-1:0] out2_data_r;

   logic             sel2_s;
   logic             in_ready_s;
   logic             take1_s;
   logic             take2_s;
   logic             drain1_s;
   logic             drain2_s;

   // Route decode and readiness; only the selected port is consulted, so a stalled
   // port never blocks traffic headed for the other one.
   always_comb begin
      sel2_s     = in_data[ROUTE_BIT];
      in_ready_s = 1'b0;
      if (!rst_n) begin
         in_ready_s = 1'b0;
      end else if (sel2_s) begin
         in_ready_s = !out2_valid_r || out2_ready;
      end else begin
         in_ready_s = !out1_valid_r || out1_ready;
      end
      take1_s  = in_valid && in_ready_s && !sel2_s;
      take2_s  = in_valid && in_ready_s &&  sel2_s;
      drain1_s = out1_valid_r && out1_ready;
      drain2_s = out2_valid_r && out2_ready;
   end

   // Port 1 holding register; a refill wins over a drain so full throughput is kept.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out1_valid_r <= 1'b0;
         out1_data_r  <= {WIDTH{1'b0}};
      end else if (take1_s) begin
         out1_valid_r <= 1'b1;
         out1_data_r  <= in_data;
      end else if (drain1_s) begin
         out1_valid_r <= 1'b0;
      end else begin
         out1_valid_r <= out1_valid_r;
      end
   end

   // Port 2 holding register, mirror of port 1.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out2_valid_r <= 1'b0;
         out2_data_r  <= {WIDTH{1'b0}};
      end else if (take2_s) begin
         out2_valid_r <= 1'b1;
         out2_data_r  <= in_data;
      end else if (drain2_s) begin
         out2_valid_r <= 1'b0;
      end else begin
         out2_valid_r <= out2_valid_r;
      end
   end

   assign in_ready   = in_ready_s;
   assign out1_valid = out1_valid_r;
   assign out1_data  = out1_data_r;
   assign out2_valid = out2_valid_r;
   assign out2_data  = out2_data_r;

endmodule

// File: tb/tb_spl_split.sv
// Bench for spl_split: directed vector table, handwritten stall/reset sequences,
// and a randomized run against a queue-based model of the two output ports.
module tb_spl_split;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [10:0] in_data;
   logic        out1_valid;
   logic        out1_ready;
   logic [10:0] out1_data;
   logic        out2_valid;
   logic        out2_ready;
   logic [10:0] out2_data;

   int checks;
   int errors;

   spl_split #(.WIDTH(11), .ROUTE_BIT(10)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .out1_valid (out1_valid),
      .out1_ready (out1_ready),
      .out1_data  (out1_data),
      .out2_valid (out2_valid),
      .out2_ready (out2_ready),
      .out2_data  (out2_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        v;
      logic [10:0] d;
      logic        r1;
      logic        r2;
      logic        rdy;
      logic        o1v;
      logic [10:0] o1d;
      logic        o2v;
      logic [10:0] o2d;
   } vec_t;

   vec_t tbl [6];

   logic [10:0] q1 [$];
   logic [10:0] q2 [$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic drive(input logic v, input logic [10:0] d, input logic r1, input logic r2);
      @(negedge clk);
      in_valid   = v;
      in_data    = d;
      out1_ready = r1;
      out2_ready = r2;
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      in_valid = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      logic exp_rdy;
      logic sel;
      checks = 0;
      errors = 0;
      rst_n = 1'b0;
      in_valid = 1'b0;
      in_data = 11'd0;
      out1_ready = 1'b0;
      out2_ready = 1'b0;

      tbl[0] = '{1'b1, 11'b10111000111, 1'b0, 1'b1, 1'b1, 1'b0, 11'd0, 1'b1, 11'b10111000111};
      tbl[1] = '{1'b1, 11'b00000000001, 1'b1, 1'b1, 1'b1, 1'b1, 11'b00000000001, 1'b0, 11'd0};
      tbl[2] = '{1'b1, 11'b00000111101, 1'b1, 1'b1, 1'b1, 1'b1, 11'b00000111101, 1'b0, 11'd0};
      tbl[3] = '{1'b1, 11'b00000000111, 1'b1, 1'b1, 1'b1, 1'b1, 11'b00000000111, 1'b0, 11'd0};
      tbl[4] = '{1'b0, 11'b00000000000, 1'b1, 1'b1, 1'b1, 1'b0, 11'd0, 1'b0, 11'd0};
      tbl[5] = '{1'b0, 11'b10000000000, 1'b0, 1'b0, 1'b1, 1'b0, 11'd0, 1'b0, 11'd0};

      // reset state
      @(posedge clk);
      @(posedge clk);
      #1;
      chk("rst_o1v", 32'(out1_valid), 32'd0);
      chk("rst_o1d", 32'(out1_data), 32'd0);
      chk("rst_o2v", 32'(out2_valid), 32'd0);
      chk("rst_o2d", 32'(out2_data), 32'd0);
      chk("rst_rdy", 32'(in_ready), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // directed vector table
      for (int i = 0; i < 6; i++) begin
         drive(tbl[i].v, tbl[i].d, tbl[i].r1, tbl[i].r2);
         chk($sformatf("tbl%0d_rdy", i), 32'(in_ready), 32'(tbl[i].rdy));
         @(posedge clk);
         #1;
         chk($sformatf("tbl%0d_o1v", i), 32'(out1_valid), 32'(tbl[i].o1v));
         chk($sformatf("tbl%0d_o2v", i), 32'(out2_valid), 32'(tbl[i].o2v));
         if (tbl[i].o1v) chk($sformatf("tbl%0d_o1d", i), 32'(out1_data), 32'(tbl[i].o1d));
         if (tbl[i].o2v) chk($sformatf("tbl%0d_o2d", i), 32'(out2_data), 32'(tbl[i].o2d));
      end

      // port 2 stalled: second port-2 packet blocked, port-1 traffic still flows
      drive(1'b1, 11'b10000000000, 1'b0, 1'b0);
      chk("stall_fill_rdy", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;
      chk("stall_o2v", 32'(out2_valid), 32'd1);
      chk("stall_o2d", 32'(out2_data), 32'(11'b10000000000));
      drive(1'b1, 11'b10000000001, 1'b0, 1'b0);
      chk("stall_block_rdy", 32'(in_ready), 32'd0);
      @(posedge clk);
      #1;
      chk("stall_hold_o2d", 32'(out2_data), 32'(11'b10000000000));
      chk("stall_hold_o2v", 32'(out2_valid), 32'd1);
      drive(1'b1, 11'b00000000011, 1'b0, 1'b0);
      chk("stall_p1_rdy", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;
      chk("stall_p1_o1v", 32'(out1_valid), 32'd1);
      chk("stall_p1_o1d", 32'(out1_data), 32'(11'b00000000011));
      chk("stall_p1_o2d", 32'(out2_data), 32'(11'b10000000000));

      // reset with port 2 full, then accept on first edge after release
      @(negedge clk);
      rst_n = 1'b0;
      in_valid = 1'b1;
      in_data = 11'b10000000101;
      #1;
      chk("mrst_rdy", 32'(in_ready), 32'd0);
      @(posedge clk);
      #1;
      chk("mrst_o2v", 32'(out2_valid), 32'd0);
      chk("mrst_o2d", 32'(out2_data), 32'd0);
      chk("mrst_o1v", 32'(out1_valid), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("mrst_rel_rdy", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;
      chk("mrst_acc_o2v", 32'(out2_valid), 32'd1);
      chk("mrst_acc_o2d", 32'(out2_data), 32'(11'b10000000101));

      // randomized run against queue model (each port holds at most one packet)
      do_reset();
      q1.delete();
      q2.delete();
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         rst_n      = ($urandom_range(0, 99) != 0);
         in_valid   = 1'($urandom_range(0, 1));
         in_data    = 11'($urandom);
         out1_ready = 1'($urandom_range(0, 1));
         out2_ready = 1'($urandom_range(0, 1));
         #1;
         sel = in_data[10];
         if (!rst_n) exp_rdy = 1'b0;
         else if (sel) exp_rdy = (q2.size() == 0) || out2_ready;
         else exp_rdy = (q1.size() == 0) || out1_ready;
         chk("rand_rdy", 32'(in_ready), 32'(exp_rdy));
         if (!rst_n) begin
            q1.delete();
            q2.delete();
         end else begin
            if (q1.size() != 0 && out1_ready) void'(q1.pop_front());
            if (q2.size() != 0 && out2_ready) void'(q2.pop_front());
            if (in_valid && exp_rdy) begin
               if (sel) q2.push_back(in_data);
               else q1.push_back(in_data);
            end
         end
         @(posedge clk);
         #1;
         chk("rand_o1v", 32'(out1_valid), 32'(q1.size() != 0));
         chk("rand_o2v", 32'(out2_valid), 32'(q2.size() != 0));
         if (q1.size() != 0) chk("rand_o1d", 32'(out1_data), 32'(q1[0]));
         if (q2.size() != 0) chk("rand_o2d", 32'(out2_data), 32'(q2[0]));
         if (!rst_n) begin
            chk("rand_rst_o1d", 32'(out1_data), 32'd0);
            chk("rand_rst_o2d", 32'(out2_data), 32'd0);
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
